// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg
// Shared definitions for the instruction-fetch stage: opcode values the
// fetch stage needs to recognise, the Branch / Jump select encodings driven
// by the branch/jump controller, and small decode helpers.
package fetch_pc_unit_pkg;

    // Opcodes the fetch stage has to know about
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    // Branch select from the controller (2'b11 is never produced)
    typedef enum logic [1:0] {
        BR_SEQ     = 2'b00,   // fall through to PC+4
        BR_PRED    = 2'b01,   // predicted taken, redirect from IF
        BR_RECOVER = 2'b10    // mispredict, restart from the ID fall-through
    } branch_sel_e;

    // Jump select from the controller (2'b11 is never produced)
    typedef enum logic [1:0] {
        J_NONE = 2'b00,
        J_IDX  = 2'b01,       // j / jal, pseudo-direct index target
        J_REG  = 2'b10        // jr, register target
    } jump_sel_e;

    // True for the conditional branches counted by the performance counter
    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // PC-relative branch target from the fall-through address and the word offset
    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Pseudo-direct jump target: upper nibble of the fall-through plus the index
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] index);
        return {pc4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_chk.sv
// fetch_pc_unit_chk
// Simulation checker for the controller inputs of the fetch stage. The
// controller must never request mispredict recovery and a jump for the same
// ID instruction; the datapath lets recovery win, but the combination means
// the controller is broken.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   branch     Branch select
//   jump       Jump select
module fetch_pc_unit_chk
    import fetch_pc_unit_pkg::*;
(
    input logic       clk,
    input logic       rst,
    input logic [1:0] branch,
    input logic [1:0] jump
);

    // Recovery and jump never target the same ID instruction
    a_recover_no_jump: assert property (@(posedge clk) disable iff (rst)
        !((branch == BR_RECOVER) && (jump != J_NONE)));

endmodule

// File: rtl/fetch_pc_unit_if_id_reg.sv
// if_id_reg
// Pipeline register between IF and ID. Holds the instruction, its PC+4 and a
// valid bit. Reset clears everything, stall holds everything, flush inserts a
// nop bubble while still capturing the fall-through address.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   stall          hold all fields
//   flush          squash the incoming instruction (instr=0, valid=0)
//   fetch_instr    instruction coming from IF
//   fetch_pc4      PC+4 coming from IF
//   id_instr       registered instruction in ID
//   id_pc4         registered PC+4 in ID
//   id_valid       0 = bubble
module if_id_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc4,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    logic [31:0] instr_r;
    logic [31:0] pc4_r;
    logic        valid_r;

    // IF/ID capture with reset > stall > flush > load priority
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r <= 32'h0000_0000;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (stall) begin
            instr_r <= instr_r;
            pc4_r   <= pc4_r;
            valid_r <= valid_r;
        end else if (flush) begin
            // pc4 still loads so a later recovery has a defined fall-through
            instr_r <= 32'h0000_0000;
            pc4_r   <= fetch_pc4;
            valid_r <= 1'b0;
        end else begin
            instr_r <= fetch_instr;
            pc4_r   <= fetch_pc4;
            valid_r <= 1'b1;
        end
    end

    assign id_instr = instr_r;
    assign id_pc4   = pc4_r;
    assign id_valid = valid_r;

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Instruction-fetch stage: PC register, next-PC mux, IF/ID register and the
// branch / mispredict performance counters.
// Parameters:
//   RESET_PC   PC after reset
//   CNT_W      performance counter width (counters wrap)
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   stall          freeze PC, IF/ID and counters
//   Branch         00 PC+4, 01 predicted taken (IF), 10 mispredict recovery (ID)
//   IF_flush       squash the instruction fetched this cycle
//   Jump           00 none, 01 j/jal, 10 jr
//   jr_target      forwarded rs of the jr in ID
//   imem_rdata     instruction at imem_addr (combinational memory)
//   imem_addr      current PC
//   if_id_instr    instruction in ID
//   if_id_pc4      PC+4 of the ID instruction
//   if_id_valid    0 = bubble in ID
//   op_if          opcode of the instruction in IF
//   branch_cnt     beq/bne instructions that left ID
//   mispred_cnt    mispredict recoveries
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       Branch,
    input  logic             IF_flush,
    input  logic [1:0]       Jump,
    input  logic [31:0]      jr_target,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [5:0]       op_if,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_r;
    logic [31:0]      pc4_s;
    logic [31:0]      br_tgt_s;
    logic [31:0]      j_tgt_s;
    logic [31:0]      next_pc_s;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispred_cnt_r;
    logic [31:0]      id_instr_s;
    logic [31:0]      id_pc4_s;
    logic             id_valid_s;

    assign pc4_s    = pc_r + 32'd4;
    assign br_tgt_s = branch_target(pc4_s, imem_rdata[15:0]);
    assign j_tgt_s  = jump_target(id_pc4_s, id_instr_s[25:0]);

    // Next-PC select: ID-stage decisions (recovery, jumps) outrank the IF prediction
    always_comb begin
        next_pc_s = pc4_s;
        if (Branch == BR_RECOVER) begin
            next_pc_s = id_pc4_s;
        end else if (Jump == J_IDX) begin
            next_pc_s = j_tgt_s;
        end else if (Jump == J_REG) begin
            next_pc_s = jr_target;
        end else if (Branch == BR_PRED) begin
            next_pc_s = br_tgt_s;
        end else begin
            next_pc_s = pc4_s;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (stall) begin
            pc_r <= pc_r;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    if_id_reg u_if_id (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (IF_flush),
        .fetch_instr (imem_rdata),
        .fetch_pc4   (pc4_s),
        .id_instr    (id_instr_s),
        .id_pc4      (id_pc4_s),
        .id_valid    (id_valid_s)
    );

    // Performance counters; a branch counts once, on the cycle it leaves ID
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_r  <= {CNT_W{1'b0}};
            mispred_cnt_r <= {CNT_W{1'b0}};
        end else if (stall) begin
            branch_cnt_r  <= branch_cnt_r;
            mispred_cnt_r <= mispred_cnt_r;
        end else begin
            if (id_valid_s && is_cond_branch(id_instr_s[31:26])) begin
                branch_cnt_r <= branch_cnt_r + CNT_ONE;
            end else begin
                branch_cnt_r <= branch_cnt_r;
            end
            if (Branch == BR_RECOVER) begin
                mispred_cnt_r <= mispred_cnt_r + CNT_ONE;
            end else begin
                mispred_cnt_r <= mispred_cnt_r;
            end
        end
    end

    fetch_pc_unit_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .branch (Branch),
        .jump   (Jump)
    );

    assign imem_addr   = pc_r;
    assign op_if       = imem_rdata[31:26];
    assign if_id_instr = id_instr_s;
    assign if_id_pc4   = id_pc4_s;
    assign if_id_valid = id_valid_s;
    assign branch_cnt  = branch_cnt_r;
    assign mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  Branch;
    logic        IF_flush;
    logic [1:0]  Jump;
    logic [31:0] jr_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  op_if;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    // narrow-counter instance, driven identically, for the wrap check
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic        w_valid;
    logic [5:0]  w_op;
    logic [3:0]  w_bcnt;
    logic [3:0]  w_mcnt;

    logic [31:0] mem [0:255];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] b;
        logic [31:0] m;
        logic [3:0]  wm;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[9:2]];

    fetch_pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .Branch(Branch), .IF_flush(IF_flush),
        .Jump(Jump), .jr_target(jr_target), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .op_if(op_if), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    fetch_pc_unit #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .stall(stall), .Branch(Branch), .IF_flush(IF_flush),
        .Jump(Jump), .jr_target(jr_target), .imem_rdata(imem_rdata),
        .imem_addr(w_addr), .if_id_instr(w_instr), .if_id_pc4(w_pc4),
        .if_id_valid(w_valid), .op_if(w_op), .branch_cnt(w_bcnt),
        .mispred_cnt(w_mcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive one cycle, push its expectation, compare after the edge
    task automatic step(input logic r, input logic st, input logic [1:0] br,
                        input logic fl, input logic [1:0] jp, input logic [31:0] jr,
                        input logic [31:0] e_pc, input logic [31:0] e_instr,
                        input logic [31:0] e_pc4, input logic e_valid,
                        input logic [31:0] e_b, input logic [31:0] e_m,
                        input logic [3:0] e_wm);
        exp_t e;
        exp_t g;
        logic [31:0] word;
        rst = r; stall = st; Branch = br; IF_flush = fl; Jump = jp; jr_target = jr;
        e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4; e.valid = e_valid;
        e.b = e_b; e.m = e_m; e.wm = e_wm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        word = mem[g.pc[9:2]];
        chk("pc",        imem_addr,          g.pc);
        chk("if_id_ins", if_id_instr,        g.instr);
        chk("if_id_pc4", if_id_pc4,          g.pc4);
        chk("valid",     {31'd0, if_id_valid}, {31'd0, g.valid});
        chk("op_if",     {26'd0, op_if},     {26'd0, word[31:26]});
        chk("br_cnt",    branch_cnt,         g.b);
        chk("mp_cnt",    mispred_cnt,        g.m);
        chk("w_pc",      w_addr,             g.pc);
        chk("w_mp_cnt",  {28'd0, w_mcnt},    {28'd0, g.wm});
    endtask

    initial begin
        logic [31:0] mpc;
        logic [31:0] mpc4;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
        mem[8'h00] = 32'h2001_0001;   // 0x3000
        mem[8'h01] = 32'h2002_0002;   // 0x3004
        mem[8'h02] = 32'h2003_0003;   // 0x3008
        mem[8'h03] = 32'h2004_0004;   // 0x300C
        mem[8'h04] = 32'h1022_0004;   // 0x3010 beq +4
        mem[8'h05] = 32'h2006_0006;   // 0x3014
        mem[8'h06] = 32'h1400_0002;   // 0x3018 bne +2
        mem[8'h09] = 32'h2005_0005;   // 0x3024
        mem[8'h0A] = 32'h0800_0C10;   // 0x3028 j 0xC10
        mem[8'h0B] = 32'h2007_0007;   // 0x302C
        mem[8'h10] = 32'h03E0_0008;   // 0x3040 jr
        mem[8'h40] = 32'h2008_0008;   // 0x3100
        mem[8'h41] = 32'h1400_0003;   // 0x3104 bne +3

        // reset overrides stall
        step(1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 32'h0, 32'h3000, 32'h0, 32'h0, 1'b0, 0, 0, 4'd0);
        step(1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 32'h0, 32'h3000, 32'h0, 32'h0, 1'b0, 0, 0, 4'd0);
        // sequential fetch
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h3004, 32'h2001_0001, 32'h3004, 1'b1, 0, 0, 4'd0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h3008, 32'h2002_0002, 32'h3008, 1'b1, 0, 0, 4'd0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h300C, 32'h2003_0003, 32'h300C, 1'b1, 0, 0, 4'd0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h3010, 32'h2004_0004, 32'h3010, 1'b1, 0, 0, 4'd0);
        // beq predicted taken in IF
        step(1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 32'h0, 32'h3024, 32'h1022_0004, 32'h3014, 1'b1, 0, 0, 4'd0);
        // mispredict recovery from ID, wrong-path fetch flushed
        step(1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 32'h0, 32'h3014, 32'h0, 32'h3028, 1'b0, 1, 1, 4'd1);
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h3018, 32'h2006_0006, 32'h3018, 1'b1, 1, 1, 4'd1);
        // bne predicted taken, correctly
        step(1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 32'h0, 32'h3024, 32'h1400_0002, 32'h301C, 1'b1, 1, 1, 4'd1);
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h3028, 32'h2005_0005, 32'h3028, 1'b1, 2, 1, 4'd1);
        // j in ID
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h302C, 32'h0800_0C10, 32'h302C, 1'b1, 2, 1, 4'd1);
        step(1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 32'h0, 32'h3040, 32'h0, 32'h3030, 1'b0, 2, 1, 4'd1);
        // jr in ID
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h3044, 32'h03E0_0008, 32'h3044, 1'b1, 2, 1, 4'd1);
        step(1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 32'h3100, 32'h3100, 32'h0, 32'h3048, 1'b0, 2, 1, 4'd1);
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h3104, 32'h2008_0008, 32'h3104, 1'b1, 2, 1, 4'd1);
        // bne predicted taken, then stalled while recovery is requested
        step(1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 32'h0, 32'h3114, 32'h1400_0003, 32'h3108, 1'b1, 2, 1, 4'd1);
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 32'h0, 32'h3114, 32'h1400_0003, 32'h3108, 1'b1, 2, 1, 4'd1);
        step(1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 32'h0, 32'h3108, 32'h0, 32'h3118, 1'b0, 3, 2, 4'd2);
        // mid-stream reset discards everything, even with stall and recovery requested
        step(1'b1, 1'b1, 2'b10, 1'b1, 2'b00, 32'h0, 32'h3000, 32'h0, 32'h0, 1'b0, 0, 0, 4'd0);
        // 16 back-to-back recoveries: narrow counter wraps to 0
        mpc  = 32'h3000;
        mpc4 = 32'h0;
        for (int k = 1; k <= 16; k++) begin
            logic [31:0] npc;
            logic [31:0] kk;
            npc = mpc4;
            kk  = k;
            step(1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 32'h0, npc, 32'h0, mpc + 32'd4, 1'b0, 0, kk, kk[3:0]);
            mpc4 = mpc + 32'd4;
            mpc  = npc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the pipelined CPU. Owns the PC register, the next-PC mux and the IF/ID pipeline register, and acts on the `Branch` and `IF_flush` decisions made by the branch/jump controller. Predicted-taken branches redirect fetch from IF, mispredictions are recovered from ID, and jumps are redirected from ID. Two performance counters, for resolved branches and mispredictions, feed the debug port.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `CNT_W`, default 32: width of the performance counters.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit stall; holds the PC and IF/ID.
- `Branch`  in  2  00 = PC+4, 01 = predicted taken (IF), 10 = mispredict recovery (ID).
- `IF_flush`  in  1  squashes the instruction fetched this cycle.
- `Jump`  in  2  00 = none, 01 = j/jal (index target), 10 = jr (register target).
- `jr_target`  in  32  rs value of the jr in ID (already forwarded).
- `imem_rdata`  in  32  instruction at `imem_addr`; combinational read.
- `imem_addr`  out  32  the current PC.
- `if_id_instr`  out  32  instruction in ID.
- `if_id_pc4`  out  32  PC+4 of the ID instruction, used as the fall-through for recovery.
- `if_id_valid`  out  1  0 = bubble.
- `op_if`  out  6  `imem_rdata[31:26]`, driven to the controller.
- `branch_cnt`  out  CNT_W  number of beq/bne instructions that left ID.
- `mispred_cnt`  out  CNT_W  number of `Branch`==10 events.

## Operation
- Combinational values:
  - `pc4 = pc + 4`.
  - `br_tgt = pc4 + {{14{imem_rdata[15]}}, imem_rdata[15:0], 2'b00}`.
  - `j_tgt = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}`.
- Next-PC priority, highest first:
  1. `rst` → `RESET_PC`.
  2. `stall` → hold.
  3. `Branch`==10 → `if_id_pc4`.
  4. `Jump`==01 → `j_tgt`.
  5. `Jump`==10 → `jr_target`.
  6. `Branch`==01 → `br_tgt`.
  7. Otherwise → `pc4`.
- IF/ID update:
  - `rst` → instr 0, pc4 0, valid 0.
  - `stall` → hold all fields.
  - `IF_flush` → instr 32'h0 (nop), valid 0; pc4 still loads `pc4`.
  - Otherwise → instr `imem_rdata`, pc4 `pc4`, valid 1.
- Counters:
  - `branch_cnt` increments when `!stall`, `if_id_valid`, and the ID opcode is beq or bne.
  - `mispred_cnt` increments when `!stall` and `Branch`==10.
  - Both wrap at 2^CNT_W.
- `Branch`==10 together with `Jump`≠00 is illegal, because the controller never produces both for one ID instruction. Recovery wins. An assertion fires in simulation.
- When a mispredict and an IF-stage `Branch`==01 coincide, the mispredict wins. The controller encodes this as `Branch`==10, so the IF prediction is dropped.

## Timing
- Reset values: `imem_addr`=`RESET_PC`, `if_id_instr`=0, `if_id_pc4`=0, `if_id_valid`=0, `branch_cnt`=0, `mispred_cnt`=0.
- Reset takes effect at the first rising edge with `rst`=1 and overrides `stall`. When `rst` is asserted mid-stream, all state is discarded at that edge.
- Predicted-taken branch: the redirect takes effect at the next edge, so there is zero bubble when the prediction is correct.
- Mispredict: the PC loads the fall-through one cycle after the branch enters ID. The wrong-path instruction in IF is flushed, costing a 1-cycle penalty.
- Jump: the PC loads the target at the edge where the jump is in ID. The IF slot is flushed, costing a 1-cycle penalty.
- `stall` freezes the PC, IF/ID and both counters for every stalled cycle. Resolution happens on the first unstalled cycle.
- The outputs are all registered except `op_if` and `imem_addr`, which equals the PC register.

## Structure
- Opcode macros (`OP_BEQ`, `OP_BNE`, j, jal) stay in the shared `instr_def.v`.
- Add to the same header: the `Branch` encodings BR_SEQ / BR_PRED / BR_RECOVER and the `Jump` encodings J_NONE / J_IDX / J_REG.
- Sub-module `if_id_reg`: holds the IF/ID register with stall/flush/reset semantics, reusable for the remaining stage registers.
- Next-PC mux and counters live in the top module.

## Test plan
- Reset: assert `rst` for 2 cycles with `stall`=1 → `imem_addr`=0x3000, `if_id_valid`=0, counters 0. After release, sequential fetch gives 0x3004, then 0x3008.
- Predicted taken:
  - Stimulus: beq at 0x3010 with imm 0x0004, `Branch`=01.
  - Next `imem_addr` = 0x3024. `if_id_pc4` = 0x3014.
  - Correct resolution: no flush. `branch_cnt` goes 0→1.
- Mispredict:
  - Stimulus: following the predicted-taken case, drive `Branch`=10, `IF_flush`=1 on the next cycle.
  - Next `imem_addr` = 0x3014. `if_id_valid`=0 for one cycle.
  - `mispred_cnt` = 1.
- Jumps:
  - j in ID with index 0x0000C10, `Jump`=01, `IF_flush`=1 → `imem_addr` = 0x0000_3040, bubble in ID.
  - jr with `jr_target` = 0x3100 → `imem_addr` = 0x3100.
- Stall:
  - Stimulus: hold `stall`=1 for 3 cycles while a bne sits in ID with `Branch`=10 asserted.
  - PC, IF/ID and counters stay unchanged for those 3 cycles.
  - Recovery happens on the cycle `stall` drops.
- Counter wrap: `CNT_W`=4 with 16 mispredicts → `mispred_cnt` returns to 0.
